wb_arbiter_2m: RTL and testbench
================================

Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter.
- Shares the SoC Wishbone slave port (CSR space holding the PWM channel registers) between the host AHB-to-FPGA bridge (master 0) and an on-fabric sequencer master (master 1).
- Round-robin ownership at cycle granularity: a grant lasts for the whole CYC assertion and is never split mid-burst.

Parameters:
- ADR_W, 15, word address width (byte address bits 16:2).
- DAT_W, 32, data width; SEL width is DAT_W/8.
- TIMEOUT, 255, cycles an unanswered strobe may wait before a forced error; used only with the optional feature; legal range 2..65535.

Ports:
- sys_clk  in  1  bus clock
- sys_rst  in  1  asynchronous reset, active-high
- m0_adr  in  ADR_W  master 0 address
- m0_dat_w  in  DAT_W  master 0 write data
- m0_dat_r  out  DAT_W  master 0 read data
- m0_sel  in  DAT_W/8  master 0 byte selects
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle, strobe and write enable
- m0_ack, m0_err  out  1 each  master 0 acknowledge and error
- m1_*  same set and widths as m0_*, for master 1
- s_adr, s_dat_w, s_sel, s_cyc, s_stb, s_we  out  widths as above  slave side
- s_dat_r  in  DAT_W  slave read data
- s_ack, s_err  in  1 each  slave acknowledge and error
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1, 00 = idle

Behaviour:
- One clock, sys_clk. Reset is asynchronous and active-high on sys_rst.
- Reset values:
  - state = IDLE, grant = 00, last_owner = m1, so m0 wins the first contest.
  - s_cyc = s_stb = s_we = 0; s_adr, s_dat_w, s_sel = 0.
  - m*_ack = m*_err = 0; m*_dat_r = 0.
- FSM states: IDLE, OWN0, OWN1; state is registered.
  - IDLE -> OWN0 if m0_cyc and (!m1_cyc or last_owner = m1).
  - IDLE -> OWN1 if m1_cyc and (!m0_cyc or last_owner = m0).
  - OWNx -> IDLE when mx_cyc is low; last_owner <= x on that transition.
- Grant latency:
  - A CYC sampled high in IDLE at edge N gives grant and s_cyc high after edge N.
  - Each ownership is followed by at least one IDLE cycle. Back-to-back transfers from different masters therefore have a one-cycle bubble.
- Muxing while in OWNx (combinational):
  - s_cyc = mx_cyc, s_stb = mx_stb; s_we, s_adr, s_dat_w, s_sel come from mx.
  - mx_ack = s_ack, mx_err = s_err, mx_dat_r = s_dat_r.
  - The non-owner sees ack = err = 0 and dat_r = 0.
  - In IDLE, all slave outputs are 0 and no ack/err reaches either master.
- No preemption. A waiting master is held indefinitely, stb asserted, with no ack, until the owner drops cyc.
- Owner drops cyc in the same cycle s_ack rises: the ack is still routed to that owner, then the FSM goes to IDLE.
- s_ack or s_err while IDLE: ignored, not forwarded.
- sys_rst asserted mid-transfer:
  - s_cyc and s_stb go to 0 immediately (asynchronous), grant = 00.
  - The in-flight transfer is abandoned with no ack.
- Fairness: with both masters holding continuous requests, ownership alternates m0, m1, m0, ...

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Enabled:
  - A counter of width clog2(TIMEOUT+1) increments each cycle with s_cyc & s_stb & !s_ack & !s_err, and clears on ack, err, or leaving OWNx.
  - When it reaches TIMEOUT, the owner gets a one-cycle mx_err = 1 and s_cyc/s_stb are forced to 0.
  - The owner stays blocked, slave outputs forced low, until mx_cyc drops, then normal release to IDLE.
  - A sticky status output `timeout_seen` (1 bit) sets on the forced error and clears only on sys_rst.
- Disabled:
  - No counter and no `timeout_seen` port.
  - m*_err is the pure pass-through of s_err.

Test Plan:
- After reset release, m0 writes adr 0x0010 with data 0xA5A5_0001, slave acks 2 cycles later -> grant = 01 one cycle after m0_cyc; s_adr = 0x0010; m0_ack one cycle; m1_ack = 0; grant = 00 the cycle after m0_cyc drops.
- m0_cyc and m1_cyc both rise in the same cycle, held for 4 single transfers each -> order m0, m1, m0, m1, ...; exactly one IDLE cycle between owners.
- m1 owns the bus with s_ack held low; m0 requests meanwhile -> m0 sees no ack and s_adr stays m1's address until m1 drops cyc; m0 is granted 2 cycles after that.
- m0 owns the bus, m0_cyc drops in the same cycle s_ack = 1 -> m0_ack = 1 that cycle; next state IDLE; no spurious ack to m1.
- sys_rst pulsed mid-read by m1 -> s_cyc = 0, grant = 00 within the same cycle without a clock edge; after release, m0 wins a simultaneous request.
- WB_ARB_TIMEOUT_EN with TIMEOUT = 8, slave never acks -> m0_err = 1 exactly 8 cycles after s_stb rises; s_cyc forced to 0; timeout_seen = 1 persisting until sys_rst.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master, one-slave Wishbone arbiter with round-robin
// ownership at CYC granularity. A grant lasts for the whole CYC assertion
// and is always followed by at least one IDLE cycle.
// Optional build macro WB_ARB_TIMEOUT_EN adds a strobe watchdog that forces
// an error to the owner after TIMEOUT unanswered cycles, plus the sticky
// timeout_seen status output.
module wb_arbiter_2m #(
   parameter int unsigned ADR_W   = 15,
   parameter int unsigned DAT_W   = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   // master 0
   input  logic [ADR_W-1:0]   m0_adr,
   input  logic [DAT_W-1:0]   m0_dat_w,
   output logic [DAT_W-1:0]   m0_dat_r,
   input  logic [DAT_W/8-1:0] m0_sel,
   input  logic               m0_cyc,
   input  logic               m0_stb,
   input  logic               m0_we,
   output logic               m0_ack,
   output logic               m0_err,
   // master 1
   input  logic [ADR_W-1:0]   m1_adr,
   input  logic [DAT_W-1:0]   m1_dat_w,
   output logic [DAT_W-1:0]   m1_dat_r,
   input  logic [DAT_W/8-1:0] m1_sel,
   input  logic               m1_cyc,
   input  logic               m1_stb,
   input  logic               m1_we,
   output logic               m1_ack,
   output logic               m1_err,
   // slave
   output logic [ADR_W-1:0]   s_adr,
   output logic [DAT_W-1:0]   s_dat_w,
   input  logic [DAT_W-1:0]   s_dat_r,
   output logic [DAT_W/8-1:0] s_sel,
   output logic               s_cyc,
   output logic               s_stb,
   output logic               s_we,
   input  logic               s_ack,
   input  logic               s_err,
   // one-hot owner: bit0 = m0, bit1 = m1
   output logic [1:0]         grant
`ifdef WB_ARB_TIMEOUT_EN
   ,
   output logic               timeout_seen
`endif
);

   localparam int unsigned SEL_W = DAT_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   // 0 = m0 owned last, 1 = m1 owned last
   logic   last_owner;
   logic   last_owner_nxt;

   // Reject unusable watchdog limits at elaboration
   generate
      if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
         $error("wb_arbiter_2m: TIMEOUT must be within 2..65535");
      end
   endgenerate

`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] to_cnt;
   logic             blocked;
   logic             to_hit;

   // Watchdog fires once per ownership, never while already blocked
   assign to_hit = (state != IDLE) && !blocked && (to_cnt == CNT_W'(TIMEOUT));
`endif

   // State and round-robin history registers
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         last_owner <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
      end
   end

   // Next-state: round-robin pick in IDLE, release only when owner drops CYC
   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
      case (state)
         IDLE: begin
            if (m0_cyc && (!m1_cyc || last_owner)) begin
               state_nxt = OWN0;
            end else if (m1_cyc) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            if (!m0_cyc) begin
               state_nxt      = IDLE;
               last_owner_nxt = 1'b0;
            end
         end
         OWN1: begin
            if (!m1_cyc) begin
               state_nxt      = IDLE;
               last_owner_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: combinational bus mux selected by the registered owner
   always_comb begin
      grant    = 2'b00;
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      s_we     = 1'b0;
      s_adr    = '0;
      s_dat_w  = '0;
      s_sel    = SEL_W'(0);
      m0_ack   = 1'b0;
      m0_err   = 1'b0;
      m0_dat_r = '0;
      m1_ack   = 1'b0;
      m1_err   = 1'b0;
      m1_dat_r = '0;
      case (state)
         OWN0: begin
            grant    = 2'b01;
            s_cyc    = m0_cyc;
            s_stb    = m0_stb;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_dat_w  = m0_dat_w;
            s_sel    = m0_sel;
            m0_ack   = s_ack;
            m0_err   = s_err;
            m0_dat_r = s_dat_r;
         end
         OWN1: begin
            grant    = 2'b10;
            s_cyc    = m1_cyc;
            s_stb    = m1_stb;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_w  = m1_dat_w;
            s_sel    = m1_sel;
            m1_ack   = s_ack;
            m1_err   = s_err;
            m1_dat_r = s_dat_r;
         end
         default: ;
      endcase
`ifdef WB_ARB_TIMEOUT_EN
      // Timed-out owner: slave side parked low, single forced error pulse
      if (blocked || to_hit) begin
         s_cyc    = 1'b0;
         s_stb    = 1'b0;
         s_we     = 1'b0;
         s_adr    = '0;
         s_dat_w  = '0;
         s_sel    = SEL_W'(0);
         m0_ack   = 1'b0;
         m1_ack   = 1'b0;
         m0_dat_r = '0;
         m1_dat_r = '0;
         m0_err   = to_hit && (state == OWN0);
         m1_err   = to_hit && (state == OWN1);
      end
`endif
   end

`ifdef WB_ARB_TIMEOUT_EN
   // Count cycles of an outstanding, unanswered strobe
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         to_cnt <= '0;
      end else if (state == IDLE || s_ack || s_err || to_hit || blocked) begin
         to_cnt <= '0;
      end else if (s_cyc && s_stb) begin
         to_cnt <= to_cnt + CNT_W'(1);
      end
   end

   // Hold the owner off the bus after a timeout until it drops CYC
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         blocked <= 1'b0;
      end else if (state_nxt == IDLE) begin
         blocked <= 1'b0;
      end else if (to_hit) begin
         blocked <= 1'b1;
      end
   end

   // Sticky record that a forced error has ever occurred
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         timeout_seen <= 1'b0;
      end else if (to_hit) begin
         timeout_seen <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: slave model with a scoreboard of
// expected slave-side transfers, plus directed checks of grant timing.
module tb_wb_arbiter_2m;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [14:0] m0_adr, m1_adr, s_adr;
   logic [31:0] m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r, s_dat_w, s_dat_r;
   logic [3:0]  m0_sel, m1_sel, s_sel;
   logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
   logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
   logic        s_cyc, s_stb, s_we, s_ack, s_err;
   logic [1:0]  grant;
`ifdef WB_ARB_TIMEOUT_EN
   logic        timeout_seen;
`endif

   logic        slv_ack, man_ack, slv_en;
   int          slv_dly, wait_cnt;
   int          n_tests = 0;
   int          n_fail  = 0;

   typedef struct {
      int          id;
      logic [14:0] adr;
      logic        we;
      logic [31:0] dat;
   } exp_t;
   exp_t sb[$];

   assign s_ack = slv_ack | man_ack;

   wb_arbiter_2m #(.ADR_W(15), .DAT_W(32), .TIMEOUT(8)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_sel(m0_sel),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_sel(m1_sel),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_ack(m1_ack), .m1_err(m1_err),
      .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_sel(s_sel),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_ack(s_ack), .s_err(s_err),
      .grant(grant)
`ifdef WB_ARB_TIMEOUT_EN
      , .timeout_seen(timeout_seen)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=still running expected=finished");
      $fatal(1, "simulation time limit");
   end

   function automatic logic [31:0] rd_data(input logic [14:0] a);
      return 32'hD00D_0000 | {17'd0, a};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave: acks slv_dly+1 edges after it first sees a strobe
   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         slv_ack  <= 1'b0;
         wait_cnt <= 0;
         s_dat_r  <= 32'd0;
      end else begin
         slv_ack <= 1'b0;
         if (slv_en && s_cyc && s_stb && !slv_ack) begin
            if (wait_cnt >= slv_dly) begin
               slv_ack  <= 1'b1;
               s_dat_r  <= rd_data(s_adr);
               wait_cnt <= 0;
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end else begin
            wait_cnt <= 0;
         end
      end
   end

   // Scoreboard: every slave ack must match the next expected transfer
   always @(negedge sys_clk) begin
      exp_t e;
      if (slv_ack) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_ack", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("sb_owner", 32'(grant), (e.id == 0) ? 32'd1 : 32'd2);
            check("sb_adr", 32'(s_adr), 32'(e.adr));
            check("sb_we", 32'(s_we), 32'(e.we));
            if (e.we) check("sb_wdat", s_dat_w, e.dat);
         end
      end
   end

   // Idle-gap monitor: exactly one IDLE cycle between successive owners
   logic       mon_en = 1'b0;
   logic       had_owner;
   int         idle_run;
   logic [1:0] prev_g;
   always @(negedge sys_clk) begin
      if (mon_en) begin
         if (grant == 2'b00) begin
            idle_run++;
         end else begin
            if (prev_g == 2'b00 && had_owner) check("idle_gap", 32'(idle_run), 32'd1);
            had_owner = 1'b1;
            idle_run  = 0;
         end
         prev_g = grant;
      end else begin
         had_owner = 1'b0;
         idle_run  = 0;
         prev_g    = 2'b00;
      end
   end

   task automatic drive_m(input int id, input logic cyc, input logic we,
                          input logic [14:0] adr, input logic [31:0] dat);
      if (id == 0) begin
         m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_adr = adr; m0_dat_w = dat;
         m0_sel = cyc ? 4'hF : 4'h0;
      end else begin
         m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_adr = adr; m1_dat_w = dat;
         m1_sel = cyc ? 4'hF : 4'h0;
      end
   endtask

   // One single transfer; CYC dropped the edge after the ack is seen
   task automatic xfer(input int id, input logic we, input logic [14:0] adr,
                       input logic [31:0] dat);
      int          n;
      logic        a;
      logic [31:0] r;
      drive_m(id, 1'b1, we, adr, dat);
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
         a = (id == 0) ? m0_ack : m1_ack;
      end while (!a && n < 200);
      check($sformatf("m%0d_xfer_ack", id), 32'(a), 32'd1);
      if (!we) begin
         r = (id == 0) ? m0_dat_r : m1_dat_r;
         check($sformatf("m%0d_rd_data", id), r, rd_data(adr));
      end
      @(posedge sys_clk); #1;
      drive_m(id, 1'b0, 1'b0, 15'd0, 32'd0);
   endtask

   task automatic push(input int id, input logic we, input logic [14:0] adr,
                       input logic [31:0] dat);
      exp_t e;
      e.id = id; e.we = we; e.adr = adr; e.dat = dat;
      sb.push_back(e);
   endtask

   task automatic pulse_reset();
      sys_rst = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
   endtask

   initial begin
      sys_rst = 1'b1;
      man_ack = 1'b0; s_err = 1'b0; slv_en = 1'b0; slv_dly = 0;
      drive_m(0, 1'b0, 1'b0, 15'd0, 32'd0);
      drive_m(1, 1'b0, 1'b0, 15'd0, 32'd0);
      pulse_reset();

      // Reset state
      @(negedge sys_clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_s_cyc", 32'(s_cyc), 32'd0);
      check("rst_s_stb", 32'(s_stb), 32'd0);
      check("rst_s_we", 32'(s_we), 32'd0);
      check("rst_s_adr", 32'(s_adr), 32'd0);
      check("rst_s_dat_w", s_dat_w, 32'd0);
      check("rst_s_sel", 32'(s_sel), 32'd0);
      check("rst_m0_ack", 32'(m0_ack), 32'd0);
      check("rst_m1_ack", 32'(m1_ack), 32'd0);
      check("rst_m0_err", 32'(m0_err), 32'd0);
      check("rst_m0_dat_r", m0_dat_r, 32'd0);

      // Single m0 write, slave acks two cycles after grant
      slv_en = 1'b1; slv_dly = 1;
      @(posedge sys_clk); #1;
      push(0, 1'b1, 15'h0010, 32'hA5A5_0001);
      drive_m(0, 1'b1, 1'b1, 15'h0010, 32'hA5A5_0001);
      @(negedge sys_clk);
      check("t1_grant_pre", 32'(grant), 32'd0);
      @(negedge sys_clk);
      check("t1_grant", 32'(grant), 32'd1);
      check("t1_s_cyc", 32'(s_cyc), 32'd1);
      check("t1_s_adr", 32'(s_adr), 32'h0010);
      check("t1_s_dat_w", s_dat_w, 32'hA5A5_0001);
      check("t1_s_sel", 32'(s_sel), 32'hF);
      @(negedge sys_clk);
      check("t1_ack_early", 32'(m0_ack), 32'd0);
      @(negedge sys_clk);
      check("t1_m0_ack", 32'(m0_ack), 32'd1);
      check("t1_m1_ack", 32'(m1_ack), 32'd0);
      @(posedge sys_clk); #1;
      drive_m(0, 1'b0, 1'b0, 15'd0, 32'd0);
      @(negedge sys_clk);
      check("t1_ack_once", 32'(m0_ack), 32'd0);
      check("t1_grant_hold", 32'(grant), 32'd1);
      @(negedge sys_clk);
      check("t1_grant_rel", 32'(grant), 32'd0);

      // Fairness: both masters request together, four transfers each
      pulse_reset();
      slv_en = 1'b1; slv_dly = 0;
      for (int i = 0; i < 4; i++) begin
         push(0, 1'b1, 15'(32'h100 + i), 32'hC0DE_0000 + 32'(i));
         push(1, 1'b0, 15'(32'h200 + i), 32'd0);
      end
      @(posedge sys_clk); #1;
      mon_en = 1'b1;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               xfer(0, 1'b1, 15'(32'h100 + i), 32'hC0DE_0000 + 32'(i));
               @(posedge sys_clk); #1;
            end
         end
         begin
            for (int j = 0; j < 4; j++) begin
               xfer(1, 1'b0, 15'(32'h200 + j), 32'd0);
               @(posedge sys_clk); #1;
            end
         end
      join
      mon_en = 1'b0;
      check("fair_sb_drained", 32'(sb.size()), 32'd0);

      // No preemption: m1 holds an unanswered strobe while m0 waits
      slv_en = 1'b0;
      @(posedge sys_clk); #1;
      drive_m(1, 1'b1, 1'b0, 15'h0123, 32'd0);
      @(negedge sys_clk); @(negedge sys_clk);
      check("np_grant_m1", 32'(grant), 32'd2);
      @(posedge sys_clk); #1;
      push(0, 1'b1, 15'h0456, 32'h1111_2222);
      drive_m(0, 1'b1, 1'b1, 15'h0456, 32'h1111_2222);
      repeat (4) begin
         @(negedge sys_clk);
         check("np_m0_no_ack", 32'(m0_ack), 32'd0);
         check("np_s_adr_m1", 32'(s_adr), 32'h0123);
      end
      @(posedge sys_clk); #1;
      drive_m(1, 1'b0, 1'b0, 15'd0, 32'd0);
      slv_en = 1'b1; slv_dly = 0;
      @(negedge sys_clk);
      check("np_grant_drop", 32'(grant), 32'd2);
      @(negedge sys_clk);
      check("np_grant_idle", 32'(grant), 32'd0);
      @(negedge sys_clk);
      check("np_grant_m0", 32'(grant), 32'd1);
      check("np_s_adr_m0", 32'(s_adr), 32'h0456);
      xfer(0, 1'b1, 15'h0456, 32'h1111_2222);

      // Owner drops CYC in the ack cycle; ack while IDLE is not forwarded
      slv_en = 1'b0;
      @(posedge sys_clk); #1;
      drive_m(0, 1'b1, 1'b0, 15'h0077, 32'd0);
      @(negedge sys_clk); @(negedge sys_clk);
      check("dr_grant", 32'(grant), 32'd1);
      @(posedge sys_clk); #1;
      man_ack = 1'b1;
      drive_m(0, 1'b0, 1'b0, 15'd0, 32'd0);
      @(negedge sys_clk);
      check("dr_m0_ack", 32'(m0_ack), 32'd1);
      check("dr_m1_ack", 32'(m1_ack), 32'd0);
      @(negedge sys_clk);
      check("dr_grant_idle", 32'(grant), 32'd0);
      check("idle_ack_m0", 32'(m0_ack), 32'd0);
      check("idle_ack_m1", 32'(m1_ack), 32'd0);
      @(posedge sys_clk); #1;
      man_ack = 1'b0;

      // Asynchronous reset in the middle of an m1 read
      slv_en = 1'b1; slv_dly = 20;
      @(posedge sys_clk); #1;
      drive_m(1, 1'b1, 1'b0, 15'h0333, 32'd0);
      @(negedge sys_clk); @(negedge sys_clk);
      check("ar_grant_m1", 32'(grant), 32'd2);
      check("ar_s_cyc_pre", 32'(s_cyc), 32'd1);
      #2 sys_rst = 1'b1;
      #1;
      check("ar_s_cyc", 32'(s_cyc), 32'd0);
      check("ar_s_stb", 32'(s_stb), 32'd0);
      check("ar_grant", 32'(grant), 32'd0);
      check("ar_m1_ack", 32'(m1_ack), 32'd0);
      @(posedge sys_clk); #1;
      drive_m(1, 1'b0, 1'b0, 15'd0, 32'd0);
      slv_en = 1'b0;
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      @(posedge sys_clk); #1;
      drive_m(0, 1'b1, 1'b0, 15'h0001, 32'd0);
      drive_m(1, 1'b1, 1'b0, 15'h0002, 32'd0);
      @(negedge sys_clk); @(negedge sys_clk);
      check("ar_m0_wins", 32'(grant), 32'd1);
      @(posedge sys_clk); #1;
      drive_m(0, 1'b0, 1'b0, 15'd0, 32'd0);
      drive_m(1, 1'b0, 1'b0, 15'd0, 32'd0);
      repeat (3) @(negedge sys_clk);

`ifdef WB_ARB_TIMEOUT_EN
      // Watchdog: slave never answers, error exactly TIMEOUT cycles after stb
      pulse_reset();
      slv_en = 1'b0;
      @(posedge sys_clk); #1;
      drive_m(0, 1'b1, 1'b1, 15'h0055, 32'h0000_BEEF);
      @(negedge sys_clk); @(negedge sys_clk);
      check("to_s_stb", 32'(s_stb), 32'd1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge sys_clk);
         check($sformatf("to_err_c%0d", k), 32'(m0_err), (k == 8) ? 32'd1 : 32'd0);
      end
      check("to_s_cyc_forced", 32'(s_cyc), 32'd0);
      check("to_s_stb_forced", 32'(s_stb), 32'd0);
      @(negedge sys_clk);
      check("to_err_once", 32'(m0_err), 32'd0);
      check("to_blocked_cyc", 32'(s_cyc), 32'd0);
      check("to_seen", 32'(timeout_seen), 32'd1);
      @(posedge sys_clk); #1;
      drive_m(0, 1'b0, 1'b0, 15'd0, 32'd0);
      @(negedge sys_clk); @(negedge sys_clk);
      check("to_grant_rel", 32'(grant), 32'd0);
      check("to_seen_sticky", 32'(timeout_seen), 32'd1);
      pulse_reset();
      @(negedge sys_clk);
      check("to_seen_clr", 32'(timeout_seen), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
